// File: rtl/slow_memory_pkg.sv
// Shared types for the slow external memory model: FSM states and counter sizing.
// No logic; consumed by obi_slow_memory_slave.
// No flow control of its own.
package slow_memory_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_WAIT,
    RESP_WAIT,
    RESP
  } slow_mem_state_e;

  // One extra bit so the largest preload value always fits.
  function automatic int cnt_width(input int gnt_latency, input int resp_latency);
    int m;
    m = (gnt_latency > resp_latency) ? gnt_latency : resp_latency;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/slow_memory_array.sv
// Word-organised storage with one synchronous read/write port and byte-enable writes.
// Read data appears one cycle after en; write lands on the same edge.
// No backpressure; contents are never reset.
module slow_memory_array #(
  parameter int WORDS = 128,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/obi_slow_memory_slave.sv
// OBI slave modelling a slow memory with programmable grant delay and response latency.
// Grant after GNT_LATENCY cycles of held req; rvalid exactly RESP_LATENCY cycles after grant.
// One outstanding transaction; no grant while a transaction is in flight or responding.
module obi_slow_memory_slave
  import slow_memory_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hF000_0000,
  parameter int          SIZE_BYTES   = 512,
  parameter int          GNT_LATENCY  = 2,
  parameter int          RESP_LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        oob_o
);

  localparam int AW    = $clog2(SIZE_BYTES);
  localparam int WORDS = SIZE_BYTES / 4;
  localparam int CW    = cnt_width(GNT_LATENCY, RESP_LATENCY);

  localparam logic [CW-1:0] GCNT_INIT = CW'((GNT_LATENCY > 0) ? GNT_LATENCY - 1 : 0);
  localparam logic [CW-1:0] RCNT_INIT = CW'(RESP_LATENCY - 1);
  localparam slow_mem_state_e AFTER_GNT = (RESP_LATENCY == 1) ? RESP : RESP_WAIT;

  slow_mem_state_e state;
  logic [CW-1:0]   gcnt, rcnt;

  logic [31:0]     off;
  logic            in_range;

  logic [AW-3:0]   idx_q;
  logic            we_q, in_range_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;

  logic [AW-3:0]   idx_cur;
  logic            we_cur, in_range_cur;
  logic [3:0]      be_cur;
  logic [31:0]     wdata_cur;

  logic            enter_resp;
  logic            rd_ok_q;
  logic            mem_en;
  logic [31:0]     mem_rdata;

  assign off      = addr_i - BASE_ADDR;
  assign in_range = (addr_i >= BASE_ADDR) && (off < 32'(SIZE_BYTES));

  always_comb begin
    gnt_o = 1'b0;
    if (!rst_i && req_i) begin
      if (state == IDLE && GNT_LATENCY == 0)     gnt_o = 1'b1;
      else if (state == GNT_WAIT && gcnt == '0)  gnt_o = 1'b1;
    end
  end

  // With a single-cycle response the memory access happens on the grant edge,
  // so the port must see the live request rather than the latched copy.
  assign idx_cur      = gnt_o ? off[AW-1:2] : idx_q;
  assign we_cur       = gnt_o ? we_i        : we_q;
  assign be_cur       = gnt_o ? be_i        : be_q;
  assign wdata_cur    = gnt_o ? wdata_i     : wdata_q;
  assign in_range_cur = gnt_o ? in_range    : in_range_q;

  assign enter_resp = (gnt_o && RESP_LATENCY == 1) ||
                      (state == RESP_WAIT && rcnt == CW'(1));
  assign mem_en     = enter_resp && in_range_cur && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      gcnt       <= '0;
      rcnt       <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      in_range_q <= 1'b0;
      rvalid_o   <= 1'b0;
      oob_o      <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      oob_o    <= 1'b0;
      rd_ok_q  <= 1'b0;

      if (gnt_o) begin
        idx_q      <= off[AW-1:2];
        we_q       <= we_i;
        be_q       <= be_i;
        wdata_q    <= wdata_i;
        in_range_q <= in_range;
        rcnt       <= RCNT_INIT;
      end

      if (enter_resp) begin
        rvalid_o <= 1'b1;
        oob_o    <= !in_range_cur;
        rd_ok_q  <= !we_cur && in_range_cur;
      end

      case (state)
        IDLE: begin
          if (req_i) begin
            if (GNT_LATENCY == 0) begin
              state <= AFTER_GNT;
            end else begin
              gcnt  <= GCNT_INIT;
              state <= GNT_WAIT;
            end
          end
        end
        GNT_WAIT: begin
          if (!req_i)           state <= IDLE;
          else if (gcnt == '0)  state <= AFTER_GNT;
          else                  gcnt  <= gcnt - CW'(1);
        end
        RESP_WAIT: begin
          rcnt <= rcnt - CW'(1);
          if (rcnt == CW'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  slow_memory_array #(
    .WORDS(WORDS),
    .AW   (AW - 2)
  ) u_array (
    .clk  (clk_i),
    .en   (mem_en),
    .we   (we_cur),
    .be   (be_cur),
    .addr (idx_cur),
    .wdata(wdata_cur),
    .rdata(mem_rdata)
  );

  // Read data is forced to zero outside a valid in-range read response.
  assign rdata_o = (rvalid_o && rd_ok_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_obi_slow_memory_slave.sv
// Bench for obi_slow_memory_slave: default-latency instance plus a zero-grant/one-cycle instance.
// Stimulus pushes expected responses; a negedge monitor pops and compares on rvalid.
module tb_obi_slow_memory_slave;

  localparam int GLAT [2] = '{2, 0};
  localparam int RLAT [2] = '{3, 1};

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        oob;
    logic        chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic        we    [2];
  logic [3:0]  be    [2];
  logic [31:0] wdata [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic [31:0] rdata [2];
  logic        oob   [2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  obi_slow_memory_slave u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .oob_o(oob[0])
  );

  obi_slow_memory_slave #(.GNT_LATENCY(0), .RESP_LATENCY(1)) u_fast (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .oob_o(oob[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: every rvalid pops one expectation; idle cycles must show rdata = 0.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (rvalid[d]) begin
          check($sformatf("gnt_during_rvalid_dut%0d", d), 32'(gnt[d]), 32'h0);
          if (qsize(d) == 0) begin
            fail_now($sformatf("unexpected_rvalid_dut%0d", d));
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("rvalid_cycle_dut%0d", d), 32'(cyc), 32'(e.cyc));
            check($sformatf("oob_dut%0d", d), 32'(oob[d]), 32'(e.oob));
            if (e.chk_data) check($sformatf("rdata_dut%0d", d), rdata[d], e.rdata);
          end
        end else begin
          check($sformatf("rdata_idle_dut%0d", d), rdata[d], 32'h0);
          check($sformatf("oob_idle_dut%0d", d), 32'(oob[d]), 32'h0);
        end
      end
    end
  end

  task automatic drive(input int d, input logic r, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] wd);
    req[d] = r; addr[d] = a; we[d] = w; be[d] = b; wdata[d] = wd;
  endtask

  task automatic wait_drain(input int d);
    for (int i = 0; i < 40 && qsize(d) != 0; i++) @(posedge clk);
    if (qsize(d) != 0) begin
      fail_now($sformatf("rvalid_timeout_dut%0d", d));
      if (d == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [3:0] b,
                      input logic [31:0] wd, input logic [31:0] er, input logic eo);
    int start;
    int g;
    bit got;
    exp_t e;
    @(posedge clk); #1;
    drive(d, 1'b1, a, w, b, wd);
    start = cyc;
    got = 0;
    g = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt[d]) begin
        got = 1;
        g = cyc;
        e = '{cyc: g + RLAT[d], rdata: er, oob: eo, chk_data: !w};
        push(d, e);
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    drive(d, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    if (!got) fail_now($sformatf("gnt_timeout_dut%0d", d));
    else      check($sformatf("gnt_latency_dut%0d", d), 32'(g - start), 32'(GLAT[d]));
    wait_drain(d);
  endtask

  initial begin
    bit got;
    int last;
    int n;
    exp_t e;

    drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive(1, 1'b1, 32'hF000_0000, 1'b0, 4'hF, 32'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_gnt_dut%0d", d), 32'(gnt[d]), 32'h0);
      check($sformatf("reset_rvalid_dut%0d", d), 32'(rvalid[d]), 32'h0);
      check($sformatf("reset_rdata_dut%0d", d), rdata[d], 32'h0);
      check($sformatf("reset_oob_dut%0d", d), 32'(oob[d]), 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

    // Default latencies: write then read back.
    xfer(0, 32'hF000_0010, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer(0, 32'hF000_0010, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte enables, including an all-zero mask.
    xfer(0, 32'hF000_0020, 1'b1, 4'hF, 32'hAABBCCDD, 32'h0, 1'b0);
    xfer(0, 32'hF000_0020, 1'b1, 4'b0101, 32'h11223344, 32'h0, 1'b0);
    xfer(0, 32'hF000_0022, 1'b0, 4'b0001, 32'h0, 32'hAA22CC44, 1'b0);
    xfer(0, 32'hF000_0020, 1'b1, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0);
    xfer(0, 32'hF000_0020, 1'b0, 4'hF, 32'h0, 32'hAA22CC44, 1'b0);

    // Out of range on both sides; word 0 must not be aliased.
    xfer(0, 32'hF000_0000, 1'b1, 4'hF, 32'h0BADF00D, 32'h0, 1'b0);
    xfer(0, 32'hF000_0200, 1'b1, 4'hF, 32'h12345678, 32'h0, 1'b1);
    xfer(0, 32'hF000_0200, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
    xfer(0, 32'hF000_0000, 1'b0, 4'hF, 32'h0, 32'h0BADF00D, 1'b0);
    xfer(0, 32'hEFFF_FFFC, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
    xfer(0, 32'hF000_01FC, 1'b1, 4'hF, 32'h600D600D, 32'h0, 1'b0);
    xfer(0, 32'hF000_01FC, 1'b0, 4'hF, 32'h0, 32'h600D600D, 1'b0);

    // Reset while the granted write is waiting for its response.
    xfer(0, 32'hF000_0004, 1'b1, 4'hF, 32'h01020304, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 32'hF000_0004, 1'b1, 4'hF, 32'h55AA55AA);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt[0]) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) fail_now("rst_test_gnt_timeout");
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    xfer(0, 32'hF000_0004, 1'b0, 4'hF, 32'h0, 32'h01020304, 1'b0);

    // Withdraw the request on the cycle it would have been granted.
    @(posedge clk); #1;
    drive(0, 1'b1, 32'hF000_0010, 1'b0, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      check($sformatf("withdraw_no_gnt_%0d", i), 32'(gnt[0]), 32'h0);
      @(posedge clk); #1;
    end
    xfer(0, 32'hF000_0010, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);

    // Zero grant latency, single-cycle response, then back-to-back reads.
    xfer(1, 32'hF000_0008, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
    xfer(1, 32'hF000_0008, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b1, 32'hF000_0008, 1'b0, 4'hF, 32'h0);
    last = 0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt[1]) begin
        if (n > 0 && (cyc - last) < 2) fail_now("b2b_grant_spacing");
        e = '{cyc: cyc + 1, rdata: 32'hCAFEF00D, oob: 1'b0, chk_data: 1'b1};
        push(1, e);
        last = cyc;
        n++;
      end
      @(posedge clk); #1;
    end
    drive(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    check("b2b_grant_count_min", 32'(n >= 3), 32'h1);
    wait_drain(1);
    xfer(1, 32'hF000_0204, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
